golomb_bit_packer: RTL and testbench

//  Downstream of the Golomb encoder. Takes one variable-length codeword per cycle and appends it MSB-first to a bitstream.

---
 rtl/golomb_bit_packer.sv | 145 ++++++++++++++
 tb/tb_golomb_bit_packer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/golomb_bit_packer.sv
// golomb_bit_packer
//   Appends variable-length Golomb codewords (1..MAX_LEN bits, MSB-first) to a
//   bitstream held left-aligned in a wide accumulator. It emits fixed WORD_W-bit
//   words on a valid/ready handshake. A flush request zero-pads the last partial
//   word and drains the accumulator.
//
//   Ports
//     clk            clock, rising edge
//     rst            synchronous reset, active-high
//     en_i           codeword valid
//     encode_data_i  codeword value, right-aligned (zero-extended)
//     encode_len_i   codeword length in bits, legal range 1..MAX_LEN
//     flush_i        pulse: pad and emit all remaining bits
//     ready_o        packer accepts a codeword this cycle
//     word_o         output word, first stream bit in bit WORD_W-1
//     word_valid_o   word_o valid
//     word_ready_i   consumer accepts word_o
//     flush_done_o   one-cycle pulse when a flush has fully drained
//     overflow_o     sticky: a codeword was dropped or its length was illegal
//     bit_count_o    (GOLOMB_PACKER_BITCNT_EN only) accepted codeword bits, mod 2^32
//
//   Optional feature macro: GOLOMB_PACKER_BITCNT_EN
//
//   state | meaning
//   RUN   | accepting codewords, popping full words
//   PAD   | round fill up to a whole word (padding bits are already zero)
//   DRAIN | pop words until empty, then pulse flush_done_o and return to RUN
module golomb_bit_packer #(
  parameter int WORD_W  = 32,
  parameter int ACC_W   = 128,
  parameter int MAX_LEN = 49,
  parameter int LEN_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [16:0]       encode_data_i,
  input  logic [LEN_W-1:0]  encode_len_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              flush_done_o,
`ifdef GOLOMB_PACKER_BITCNT_EN
  output logic [31:0]       bit_count_o,
`endif
  output logic              overflow_o
);

  localparam int FILL_W = $clog2(ACC_W + 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PAD   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [FILL_W-1:0] READY_MAX = FILL_W'(ACC_W - MAX_LEN - WORD_W);
  localparam logic [FILL_W-1:0] WORD_F    = FILL_W'(WORD_W);
  localparam logic [FILL_W-1:0] WORD_M1   = FILL_W'(WORD_W - 1);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [1:0]        state_q, state_d;
  logic              ovf_q, ovf_d;

  logic              pop, push, len_ok;
  logic [ACC_W-1:0]  acc_base, ins;
  logic [FILL_W-1:0] fill_base, fill_rnd, ins_sh;
  logic [63:0]       data_ext, len_mask;

  assign word_valid_o = (fill_q >= WORD_F);
  assign word_o       = acc_q[ACC_W-1 -: WORD_W];
  assign ready_o      = (state_q == ST_RUN) && (fill_q <= READY_MAX);
  assign flush_done_o = (state_q == ST_DRAIN) && (fill_q == '0);
  assign overflow_o   = ovf_q;

  assign pop    = word_valid_o && word_ready_i;
  assign len_ok = (encode_len_i != '0) && (encode_len_i <= LEN_W'(MAX_LEN));
  assign push   = en_i && ready_o && len_ok;

  // A same-cycle pop shifts first so the new codeword lands right after the
  // bits that remain.
  assign acc_base  = pop ? (acc_q << WORD_W) : acc_q;
  assign fill_base = pop ? (fill_q - WORD_F) : fill_q;

  // Bits below fill are always zero, so the codeword can be OR-ed into place.
  assign data_ext = 64'(encode_data_i);
  assign len_mask = (64'd1 << encode_len_i) - 64'd1;
  assign ins_sh   = FILL_W'(ACC_W) - fill_base - FILL_W'(encode_len_i);
  assign ins      = ACC_W'(data_ext & len_mask) << ins_sh;

  assign fill_rnd = (fill_base + WORD_M1) & ~WORD_M1;

  always_comb begin
    acc_d   = acc_base;
    fill_d  = fill_base;
    state_d = state_q;
    ovf_d   = ovf_q;
    if (push) begin
      acc_d  = acc_base | ins;
      fill_d = fill_base + FILL_W'(encode_len_i);
    end
    if (en_i && (!ready_o || !len_ok)) ovf_d = 1'b1;
    case (state_q)
      ST_RUN: begin
        if (flush_i) state_d = ST_PAD;
      end
      ST_PAD: begin
        fill_d  = fill_rnd;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fill_q == '0) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      fill_q  <= '0;
      state_q <= ST_RUN;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef GOLOMB_PACKER_BITCNT_EN
  logic [31:0] bit_cnt_q, bit_cnt_d;

  assign bit_cnt_d   = push ? (bit_cnt_q + 32'(encode_len_i)) : bit_cnt_q;
  assign bit_count_o = bit_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) bit_cnt_q <= '0;
    else     bit_cnt_q <= bit_cnt_d;
  end
`endif

endmodule

// File: tb/tb_golomb_bit_packer.sv
module tb_golomb_bit_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic [16:0] encode_data_i;
  logic [6:0]  encode_len_i;
  logic        flush_i;
  logic        ready_o;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        flush_done_o;
  logic        overflow_o;
`ifdef GOLOMB_PACKER_BITCNT_EN
  logic [31:0] bit_count_o;
`endif

  golomb_bit_packer dut (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en_i),
    .encode_data_i (encode_data_i),
    .encode_len_i  (encode_len_i),
    .flush_i       (flush_i),
    .ready_o       (ready_o),
    .word_o        (word_o),
    .word_valid_o  (word_valid_o),
    .word_ready_i  (word_ready_i),
    .flush_done_o  (flush_done_o),
`ifdef GOLOMB_PACKER_BITCNT_EN
    .bit_count_o   (bit_count_o),
`endif
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en_i = 1'b0; flush_i = 1'b0;
    encode_data_i = '0; encode_len_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [16:0] data;
    logic [6:0]  len;
    int          n_words;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] got[4];
    int          n_got, n_done;
    logic [31:0] held;
    bit          q[$];
    logic [31:0] exp_w;
    logic [16:0] d;
    bit          exp_valid;

    vecs[0] = '{17'h00005, 7'd3,  1, 32'hA0000000, 32'h0,        1'b0};
    vecs[1] = '{17'h1ABCD, 7'd49, 2, 32'h00000000, 32'hD5E68000, 1'b0};
    vecs[2] = '{17'h00001, 7'd1,  1, 32'h80000000, 32'h0,        1'b0};
    vecs[3] = '{17'h1FFFF, 7'd32, 1, 32'h0001FFFF, 32'h0,        1'b0};
    vecs[4] = '{17'h00001, 7'd33, 2, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5] = '{17'h1ABCD, 7'd5,  1, 32'h68000000, 32'h0,        1'b0};
    vecs[6] = '{17'h10001, 7'd17, 1, 32'h80008000, 32'h0,        1'b0};
    vecs[7] = '{17'h00005, 7'd0,  0, 32'h0,        32'h0,        1'b1};
    vecs[8] = '{17'h00005, 7'd50, 0, 32'h0,        32'h0,        1'b1};
    vecs[9] = '{17'h1FFFF, 7'd49, 2, 32'h00000000, 32'hFFFF8000, 1'b1 ^ 1'b1};

    word_ready_i = 1'b1;
    do_reset();
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(word_valid_o), 32'd0);
    chk("rst_word", word_o, 32'h0);
    chk("rst_done", 32'(flush_done_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);

    // single codeword pushed in the same cycle as flush
    for (int v = 0; v < 10; v++) begin
      word_ready_i = 1'b1;
      do_reset();
      en_i = 1'b1; flush_i = 1'b1;
      encode_data_i = vecs[v].data; encode_len_i = vecs[v].len;
      @(negedge clk);
      en_i = 1'b0; flush_i = 1'b0;
      n_got = 0; n_done = 0;
      for (int c = 0; c < 12; c++) begin
        if (word_valid_o) begin
          if (n_got < 4) got[n_got] = word_o;
          n_got++;
        end
        if (flush_done_o) n_done++;
        @(negedge clk);
      end
      chk($sformatf("v%0d_nwords", v), 32'(n_got), 32'(vecs[v].n_words));
      if (vecs[v].n_words >= 1) chk($sformatf("v%0d_w0", v), got[0], vecs[v].w0);
      if (vecs[v].n_words >= 2) chk($sformatf("v%0d_w1", v), got[1], vecs[v].w1);
      chk($sformatf("v%0d_done", v), 32'(n_done), 32'd1);
      chk($sformatf("v%0d_ovf", v), 32'(overflow_o), 32'(vecs[v].ovf));
`ifdef GOLOMB_PACKER_BITCNT_EN
      chk($sformatf("v%0d_bitcnt", v), bit_count_o, vecs[v].ovf ? 32'd0 : 32'(vecs[v].len));
`endif
    end

    // 32 single-bit ones make one all-ones word
    word_ready_i = 1'b1;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      en_i = 1'b1; encode_data_i = 17'd1; encode_len_i = 7'd1;
      @(negedge clk);
    end
    en_i = 1'b0;
    chk("t1_valid", 32'(word_valid_o), 32'd1);
    chk("t1_word", word_o, 32'hFFFFFFFF);
    @(negedge clk);
    chk("t1_empty", 32'(word_valid_o), 32'd0);
    chk("t1_ovf", 32'(overflow_o), 32'd0);

    // back-pressure: ready falls, extra codeword overflows, word_o holds
    word_ready_i = 1'b0;
    do_reset();
    en_i = 1'b1; encode_data_i = 17'h1ABCD; encode_len_i = 7'd17;
    @(negedge clk);
    chk("t4_ready17", 32'(ready_o), 32'd1);
    encode_data_i = 17'h15555; encode_len_i = 7'd17;
    @(negedge clk);
    chk("t4_ready34", 32'(ready_o), 32'd1);
    encode_data_i = 17'h0; encode_len_i = 7'd49;
    @(negedge clk);
    chk("t4_ready83", 32'(ready_o), 32'd0);
    chk("t4_valid", 32'(word_valid_o), 32'd1);
    chk("t4_word", word_o, 32'hD5E6D555);
    chk("t4_ovf0", 32'(overflow_o), 32'd0);
    held = word_o;
    encode_data_i = 17'h1; encode_len_i = 7'd1;
    @(negedge clk);
    en_i = 1'b0;
    chk("t4_ovf1", 32'(overflow_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold", word_o, held);
      @(negedge clk);
    end
    word_ready_i = 1'b1;
    @(negedge clk);
    chk("t4_word2", word_o, 32'h40000000);
    @(negedge clk);
    chk("t4_drained", 32'(word_valid_o), 32'd0);
    chk("t4_ready19", 32'(ready_o), 32'd1);

    // ready boundary: fill 47 still ready, 48 not
    word_ready_i = 1'b0;
    do_reset();
    en_i = 1'b1; encode_data_i = 17'h0; encode_len_i = 7'd47;
    @(negedge clk);
    chk("bnd_ready47", 32'(ready_o), 32'd1);
    encode_len_i = 7'd1;
    @(negedge clk);
    en_i = 1'b0;
    chk("bnd_ready48", 32'(ready_o), 32'd0);
    chk("bnd_ovf", 32'(overflow_o), 32'd0);

    // streaming push+pop vs bit-serial model
    word_ready_i = 1'b1;
    do_reset();
    q.delete();
    for (int c = 0; c < 80; c++) begin
      exp_valid = (q.size() >= 32);
      chk("t5_valid", 32'(word_valid_o), 32'(exp_valid));
      if (exp_valid) begin
        exp_w = '0;
        for (int b = 0; b < 32; b++) exp_w = {exp_w[30:0], q.pop_front()};
        chk("t5_word", word_o, exp_w);
      end
      if (ready_o) begin
        d = 17'($urandom_range(0, 32'h1FFFF));
        en_i = 1'b1; encode_data_i = d; encode_len_i = 7'd40;
        for (int b = 39; b >= 0; b--) q.push_back(b < 17 ? d[b] : 1'b0);
      end else begin
        en_i = 1'b0;
      end
      @(negedge clk);
    end
    en_i = 1'b0;
    chk("t5_ovf", 32'(overflow_o), 32'd0);

    // reset during drain discards everything, no done pulse
    word_ready_i = 1'b0;
    do_reset();
    en_i = 1'b1; flush_i = 1'b1; encode_data_i = 17'h1ABCD; encode_len_i = 7'd49;
    @(negedge clk);
    en_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_pre_valid", 32'(word_valid_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_valid", 32'(word_valid_o), 32'd0);
    chk("t6_ready", 32'(ready_o), 32'd1);
    chk("t6_word", word_o, 32'h0);
    n_done = 0;
    for (int c = 0; c < 5; c++) begin
      if (flush_done_o) n_done++;
      @(negedge clk);
    end
    chk("t6_nodone", 32'(n_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
